// File: rtl/traffic_lgt_monitor.sv
// Passive checker for the traffic light controller outputs.
// Tracks the highway/country phase sequence, raises sticky error flags for
// illegal codes, conflicting greens, out-of-order transitions, short
// yellow/all-red dwell and unrequested country green, and counts green entries.
module traffic_lgt_monitor #(
    parameter int unsigned Y_MIN = 3,
    parameter int unsigned R_MIN = 2,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          x,
    input  logic [1:0]    hwy,
    input  logic [1:0]    cntry,
    input  logic          clr_err,
    output logic          err_code,
    output logic          err_conflict,
    output logic          err_seq,
    output logic          err_dwell,
    output logic          err_req,
    output logic          fault,
    output logic [2:0]    phase,
    output logic [CW-1:0] hwy_cnt,
    output logic [CW-1:0] cntry_cnt
);

    typedef enum logic [1:0] {RED = 2'd0, YEL = 2'd1, GRN = 2'd2, BAD = 2'd3} light_t;

    typedef enum logic [2:0] {
        SYNC = 3'd0, HG = 3'd1, HY = 3'd2, AR1 = 3'd3,
        CG   = 3'd4, CY = 3'd5, AR2 = 3'd6
    } state_t;

    localparam logic [CW-1:0] Y_LIM = CW'(Y_MIN);
    localparam logic [CW-1:0] R_LIM = CW'(R_MIN);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t        state, nxt;
    logic [CW-1:0] dwell;
    logic          req_seen;

    logic p_gr, p_yr, p_rr, p_rg, p_ry;
    logic set_code, set_conf, set_seq, set_dwell, set_req;
    logic code_n, conf_n, seq_n, dwell_n, req_n;
    logic hg_entry, cg_entry, in_req;

    assign phase = state;

    // Next-state decode and per-cycle violation detection
    always_comb begin
        p_gr = (hwy == GRN) && (cntry == RED);
        p_yr = (hwy == YEL) && (cntry == RED);
        p_rr = (hwy == RED) && (cntry == RED);
        p_rg = (hwy == RED) && (cntry == GRN);
        p_ry = (hwy == RED) && (cntry == YEL);

        set_code  = (hwy == BAD) || (cntry == BAD);
        // two illegal codes are reported only as a code error
        set_conf  = (hwy != RED) && (cntry != RED) && !((hwy == BAD) && (cntry == BAD));
        set_seq   = 1'b0;
        set_dwell = 1'b0;
        set_req   = 1'b0;
        nxt       = state;

        if (set_code || set_conf) begin
            nxt = SYNC;
        end else begin
            case (state)
                SYNC: if (p_gr) nxt = HG;
                HG: begin
                    if (p_yr) nxt = HY;
                    else if (!p_gr) begin set_seq = 1'b1; nxt = SYNC; end
                end
                HY: begin
                    if (p_rr) begin
                        nxt = AR1;
                        set_dwell = (dwell < Y_LIM);
                    end else if (!p_yr) begin set_seq = 1'b1; nxt = SYNC; end
                end
                AR1: begin
                    if (p_rg) begin
                        nxt = CG;
                        set_dwell = (dwell < R_LIM);
                        // a request arriving on the same edge as the green counts
                        set_req = !(req_seen || x);
                    end else if (!p_rr) begin set_seq = 1'b1; nxt = SYNC; end
                end
                CG: begin
                    if (p_ry) nxt = CY;
                    else if (!p_rg) begin set_seq = 1'b1; nxt = SYNC; end
                end
                CY: begin
                    if (p_rr) begin
                        nxt = AR2;
                        set_dwell = (dwell < Y_LIM);
                    end else if (p_gr) begin
                        nxt = HG;
                        set_dwell = (dwell < Y_LIM);
                    end else if (!p_ry) begin set_seq = 1'b1; nxt = SYNC; end
                end
                AR2: begin
                    if (p_gr) begin
                        nxt = HG;
                        set_dwell = (dwell < R_LIM);
                    end else if (!p_rr) begin set_seq = 1'b1; nxt = SYNC; end
                end
                default: nxt = SYNC;
            endcase
        end

        hg_entry = (nxt == HG) && (state != HG);
        cg_entry = (nxt == CG) && (state != CG);
        in_req   = (state == HG) || (state == HY) || (state == AR1);

        code_n  = (err_code     && !clr_err) || set_code;
        conf_n  = (err_conflict && !clr_err) || set_conf;
        seq_n   = (err_seq      && !clr_err) || set_seq;
        dwell_n = (err_dwell    && !clr_err) || set_dwell;
        req_n   = (err_req      && !clr_err) || set_req;
    end

    // Registered state, dwell, request tracking, counters and sticky flags
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state        <= SYNC;
            dwell        <= '0;
            req_seen     <= 1'b0;
            hwy_cnt      <= '0;
            cntry_cnt    <= '0;
            err_code     <= 1'b0;
            err_conflict <= 1'b0;
            err_seq      <= 1'b0;
            err_dwell    <= 1'b0;
            err_req      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)    dwell <= ONE;
            else if (dwell != '1) dwell <= dwell + ONE;

            if (hg_entry)          req_seen <= 1'b0;
            else if (in_req && x)  req_seen <= 1'b1;

            if (hg_entry) hwy_cnt   <= hwy_cnt + ONE;
            if (cg_entry) cntry_cnt <= cntry_cnt + ONE;

            err_code     <= code_n;
            err_conflict <= conf_n;
            err_seq      <= seq_n;
            err_dwell    <= dwell_n;
            err_req      <= req_n;
            fault        <= code_n || conf_n || seq_n || dwell_n || req_n;
        end
    end

endmodule
